load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port; sits between the execute stage and the byte-banked data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the memory's address, write-data, enable and size lines, then returns load data with sign or zero extension.
- Misaligned halfword/word accesses are split into sequential byte beats, because the memory ignores the low address bits for those sizes.

Parameters:
ADDR_WIDTH, 32, width of req_addr and mem_access_addr

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  3  funct3 code: 000 b, 001 h, 010 w, 100 bu, 101 hu; others treated as w
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle pulse: access complete
resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores
resp_misaligned  output  1  misalignment flag, valid with resp_valid
mem_access_addr  output  ADDR_WIDTH  memory byte address
mem_in  output  32  memory write data
mem_write_en  output  1  memory write strobe; memory writes on rising clk
mem_read_en  output  1  memory read enable
mem_data_size  output  3  memory size code
mem_out  input  32  combinational memory read data

Behaviour:
- Reset: asynchronous, immediate.
  - All mem_* outputs = 0; resp_valid = 0; resp_rdata = 0; resp_misaligned = 0; req_ready = 1; state = IDLE.
- Request latching: a request is accepted on a clock edge where req_valid and req_ready are both high. addr, size, write and wdata are latched at that edge.
- Alignment test:
  - Byte sizes are always aligned.
  - Halfword is aligned when addr[0] = 0.
  - Word is aligned when addr[1:0] = 0.
- States: IDLE, ACCESS, SPLIT, RESP.
  - IDLE: accept request; go to ACCESS if aligned, SPLIT if misaligned.
  - ACCESS: exactly one cycle of enable. mem_access_addr = latched addr. Read data is captured into a result register at the end of this cycle. Next state is RESP.
  - SPLIT: beat counter k = 0..N-1, with N = 2 for halfword and N = 4 for word.
    - mem_access_addr = addr + k, computed modulo 2^ADDR_WIDTH (wraps).
    - Loads: mem_data_size = 100. mem_out[7:0] goes into result byte k (little-endian).
    - Stores: mem_data_size = 000. mem_in[7:0] = wdata byte k.
    - After beat N-1, go to RESP.
  - RESP: resp_valid = 1 for one cycle, then IDLE. Enables are low in this state.
- Store size normalisation (memory treats unknown codes as word):
  - size[1:0] = 00 → 000.
  - size[1:0] = 01 → 001.
  - Anything else → 010.
- Load sizes pass through unchanged in ACCESS. mem_in = wdata in ACCESS.
- Load extension in RESP:
  - 000: sign-extend from bit 7. 001: sign-extend from bit 15.
  - 100 and 101: zero-extend.
  - Word: unchanged.
  - The memory already extends aligned loads; the unit re-extends uniformly.
- Enables: mem_read_en/mem_write_en are high only in ACCESS/SPLIT, and never both at once. All mem_* outputs are 0 outside ACCESS/SPLIT.
- Latency, for a request accepted at edge T:
  - Aligned: resp_valid in cycle T+2.
  - Misaligned: resp_valid in cycle T+N+1.
- Back-to-back: next acceptance possible in the RESP→IDLE cycle following resp_valid. There is no overlap.
- Reset mid-SPLIT: abort immediately with no further beats. Bytes already written remain in memory; no response is issued.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: misaligned requests bypass SPLIT.
  - No memory enable is asserted.
  - resp_valid pulses in cycle T+1 with resp_misaligned = 1 and resp_rdata = 0.
  - Aligned behaviour is unchanged.
- Undefined: misaligned requests are split as above; resp_misaligned is constant 0.

Test Plan:
Memory preload for all scenarios: bytes 0x10..0x17 = 11 22 33 44 85 66 77 88.
1. lw at 0x10 → single read cycle, mem_data_size 010, resp_rdata 0x44332211 at T+2.
2. lh at 0x13 (misaligned) → byte reads at 0x13, 0x14 with size 100; resp_rdata 0xFFFF8544 at T+3. lhu at 0x13 → 0x00008544.
3. sw 0xDEADBEEF at 0x11 → byte writes 0x11=EF, 0x12=BE, 0x13=AD, 0x14=DE; then lw at 0x10 → 0xADBEEF11.
4. Store with req_size 100 and wdata 0x000000A5 at 0x16 → mem_data_size 000, only 0x16 changes; lw at 0x14 → 0x88A56685.
5. rst_n low during beat 2 of a misaligned sw at 0x11 → all mem_* go to 0 asynchronously, no resp_valid, only 0x11 and 0x12 written, req_ready = 1 after release.
6. With MISALIGN_TRAP_EN: lw at 0x12 → no enables, resp_valid at T+1, resp_misaligned = 1, resp_rdata = 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-banked data memory: aligned accesses in one beat,
// misaligned halfword/word split into byte beats. Define MISALIGN_TRAP_EN to trap misaligned requests instead.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | single aligned memory beat, load data captured
// SPLIT  | byte beats k = 0..N-1 for a misaligned access
// RESP   | one-cycle response pulse
module load_store_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_misaligned,
   output logic [ADDR_WIDTH-1:0] mem_access_addr,
   output logic [31:0]           mem_in,
   output logic                  mem_write_en,
   output logic                  mem_read_en,
   output logic [2:0]            mem_data_size,
   input  logic [31:0]           mem_out
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            size_q;
   logic                  write_q;
   logic [31:0]           wdata_q;
   logic [31:0]           result_q;
   logic [1:0]            beat_q;
   logic                  accept;
   logic                  misaligned_req;
   logic                  last_beat;
   logic [31:0]           load_ext;
   logic [2:0]            store_size;

   assign accept = req_valid && (state == S_IDLE);

   always_comb begin
      case (req_size[1:0])
         2'b00:   misaligned_req = 1'b0;
         2'b01:   misaligned_req = req_addr[0];
         default: misaligned_req = |req_addr[1:0];
      endcase
   end

   assign last_beat = (size_q[1:0] == 2'b01) ? (beat_q == 2'd1) : (beat_q == 2'd3);

   always_comb begin
      case (size_q[1:0])
         2'b00:   store_size = 3'b000;
         2'b01:   store_size = 3'b001;
         default: store_size = 3'b010;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic trap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         trap_q <= 1'b0;
      else if (accept)
         trap_q <= misaligned_req;
   end

   assign resp_misaligned = (state == S_RESP) && trap_q;
`else
   assign resp_misaligned = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         size_q   <= 3'b000;
         write_q  <= 1'b0;
         wdata_q  <= 32'h0;
         result_q <= 32'h0;
         beat_q   <= 2'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  addr_q   <= req_addr;
                  size_q   <= req_size;
                  write_q  <= req_write;
                  wdata_q  <= req_wdata;
                  result_q <= 32'h0;
                  beat_q   <= 2'd0;
               end
            end
            S_ACCESS: begin
               if (!write_q)
                  result_q <= mem_out;
            end
            S_SPLIT: begin
               beat_q <= beat_q + 2'd1;
               if (!write_q)
                  result_q[{beat_q, 3'b000} +: 8] <= mem_out[7:0];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
`ifdef MISALIGN_TRAP_EN
               state_nxt = misaligned_req ? S_RESP : S_ACCESS;
`else
               state_nxt = misaligned_req ? S_SPLIT : S_ACCESS;
`endif
            end
         end
         S_ACCESS: state_nxt = S_RESP;
         S_SPLIT:  state_nxt = last_beat ? S_RESP : S_SPLIT;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Aligned loads are already extended by the memory; re-extending keeps split and aligned paths uniform.
   always_comb begin
      case (size_q)
         3'b000:  load_ext = {{24{result_q[7]}}, result_q[7:0]};
         3'b001:  load_ext = {{16{result_q[15]}}, result_q[15:0]};
         3'b100:  load_ext = {24'h0, result_q[7:0]};
         3'b101:  load_ext = {16'h0, result_q[15:0]};
         default: load_ext = result_q;
      endcase
   end

   always_comb begin
      req_ready       = (state == S_IDLE);
      resp_valid      = (state == S_RESP);
      resp_rdata      = 32'h0;
      mem_access_addr = '0;
      mem_in          = 32'h0;
      mem_write_en    = 1'b0;
      mem_read_en     = 1'b0;
      mem_data_size   = 3'b000;
      case (state)
         S_ACCESS: begin
            mem_access_addr = addr_q;
            mem_in          = wdata_q;
            mem_write_en    = write_q;
            mem_read_en     = !write_q;
            mem_data_size   = write_q ? store_size : size_q;
         end
         S_SPLIT: begin
            mem_access_addr = addr_q + {{(ADDR_WIDTH-2){1'b0}}, beat_q};
            mem_write_en    = write_q;
            mem_read_en     = !write_q;
            mem_data_size   = write_q ? 3'b000 : 3'b100;
            if (write_q)
               mem_in = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
         end
         S_RESP: begin
            if (!write_q && !resp_misaligned)
               resp_rdata = load_ext;
         end
         default: ;
      endcase
   end

endmodule
